// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and round-robin helper for the player move controller
package game_pkg;

  localparam int DIR_COUNT = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic x;
    logic y;
  } grid_pos_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } move_state_t;

  // First requesting direction at or after start; meaningful only when req != 0.
  function automatic dir_t rr_pick(input logic [DIR_COUNT-1:0] req, input dir_t start);
    dir_t       pick;
    logic [1:0] idx;
    pick = start;
    for (int i = DIR_COUNT - 1; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) pick = dir_t'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchronizer, stability counter and press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level, armed;
  logic [CW-1:0] cnt;
  logic          differ;

  // Until a stable release is seen, count released samples instead, so a
  // button held across reset cannot produce a press.
  always_comb begin
    differ = armed ? (sync2 != level) : ~sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      armed <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (armed) begin
          level <= sync2;
          press <= sync2;
        end else begin
          armed <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - debounced 4-button player mover on a 2x2 grid, one move per frame_tick
// Optional PLAYER_MOVE_WRAP_EN: edge moves toggle the coordinate instead of being blocked.
module player_move_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up,
  input  logic down,
  input  logic right,
  input  logic left,
  input  logic frame_tick,
  output logic pos_x,
  output logic pos_y,
  output logic move_valid,
  output logic move_blocked,
  output logic busy
);

  logic [DIR_COUNT-1:0] raw, press, pending, pending_nxt;
  move_state_t          state, state_nxt;
  dir_t                 rr_start, grant_dir;
  grid_pos_t            pos, move_pos, pos_nxt;
  logic                 grant, changed, valid_nxt, blocked_nxt;

  assign raw = {left, right, down, up};

  for (genvar i = 0; i < DIR_COUNT; i++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (raw[i]),
      .press (press[i])
    );
  end

  always_comb begin
    grant       = (state == ST_PENDING) && frame_tick;
    grant_dir   = rr_pick(pending, rr_start);
    pending_nxt = pending;
    if (grant) pending_nxt[grant_dir] = 1'b0;
    // A fresh press of the granted direction re-arms it in the same cycle.
    pending_nxt = pending_nxt | press;

    move_pos = pos;
    case (grant_dir)
      DIR_UP:    move_pos.y = 1'b1;
      DIR_DOWN:  move_pos.y = 1'b0;
      DIR_RIGHT: move_pos.x = 1'b1;
      default:   move_pos.x = 1'b0;
    endcase
    changed = (move_pos != pos);
`ifdef PLAYER_MOVE_WRAP_EN
    if (!changed) begin
      if (grant_dir == DIR_UP || grant_dir == DIR_DOWN) move_pos.y = ~pos.y;
      else                                              move_pos.x = ~pos.x;
    end
    valid_nxt   = grant;
    blocked_nxt = 1'b0;
`else
    valid_nxt   = grant && changed;
    blocked_nxt = grant && !changed;
`endif
    pos_nxt = grant ? move_pos : pos;

    if (grant)            state_nxt = ST_COMMIT;
    else if (|pending_nxt) state_nxt = ST_PENDING;
    else                  state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pending      <= '0;
      busy         <= 1'b0;
      pos          <= '0;
      move_valid   <= 1'b0;
      move_blocked <= 1'b0;
      rr_start     <= DIR_UP;
    end else begin
      state        <= state_nxt;
      pending      <= pending_nxt;
      busy         <= |pending_nxt;
      pos          <= pos_nxt;
      move_valid   <= valid_nxt;
      move_blocked <= blocked_nxt;
      if (grant) rr_start <= dir_t'(grant_dir + 2'd1);
    end
  end

  assign pos_x = pos.x;
  assign pos_y = pos.y;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed and randomized checks of player_move_ctrl against an event-level model
module tb_player_move_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n, up, down, right, left, frame_tick;
  logic pos_x, pos_y, move_valid, move_blocked, busy;

  always #5 clk = ~clk;

  player_move_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .up           (up),
    .down         (down),
    .right        (right),
    .left         (left),
    .frame_tick   (frame_tick),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .move_valid   (move_valid),
    .move_blocked (move_blocked),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: bit order 0=up 1=down 2=right 3=left
  bit       m_x, m_y;
  bit [3:0] m_pend, m_armed, m_level, held;
  int       m_start;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit [3:0] b);
    {left, right, down, up} = b;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".pos_x"}, pos_x, m_x);
    check_eq({tag, ".pos_y"}, pos_y, m_y);
    check_eq({tag, ".move_valid"}, move_valid, 1'b0);
    check_eq({tag, ".move_blocked"}, move_blocked, 1'b0);
    check_eq({tag, ".busy"}, busy, m_pend != 0);
  endtask

  // Buttons have been stable long enough for the debouncer to settle.
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      if (!held[i]) begin
        m_armed[i] = 1'b1;
        m_level[i] = 1'b0;
      end else if (m_armed[i] && !m_level[i]) begin
        m_level[i] = 1'b1;
        m_pend[i]  = 1'b1;
      end
    end
  endtask

  task automatic phase(input bit [3:0] b);
    held = b;
    drive(b);
    step(12);
    settle();
    check_quiet("phase");
  endtask

  task automatic glitch(input int i);
    bit [3:0] g;
    g    = held;
    g[i] = ~g[i];
    drive(g);
    step(2);
    drive(held);
    step(12);
    settle();
    check_quiet("glitch");
  endtask

  task automatic tick(input bit dbl);
    bit g, v, bl;
    int d, dd;
    bit nx, ny;
    g = 0; v = 0; bl = 0; d = 0;
    for (int k = 0; k < 4; k++) begin
      dd = (m_start + k) % 4;
      if (!g && m_pend[dd]) begin
        g = 1;
        d = dd;
      end
    end
    if (g) begin
      m_pend[d] = 1'b0;
      m_start   = (d + 1) % 4;
      nx = m_x; ny = m_y;
      case (d)
        0: ny = 1'b1;
        1: ny = 1'b0;
        2: nx = 1'b1;
        default: nx = 1'b0;
      endcase
      if (nx == m_x && ny == m_y) begin
`ifdef PLAYER_MOVE_WRAP_EN
        if (d < 2) ny = ~m_y;
        else       nx = ~m_x;
        v = 1;
`else
        bl = 1;
`endif
      end else begin
        v = 1;
      end
      m_x = nx; m_y = ny;
    end
    frame_tick = 1'b1;
    step(1);
    frame_tick = dbl;
    check_eq("tick.pos_x", pos_x, m_x);
    check_eq("tick.pos_y", pos_y, m_y);
    check_eq("tick.move_valid", move_valid, v);
    check_eq("tick.move_blocked", move_blocked, bl);
    check_eq("tick.busy", busy, m_pend != 0);
    step(1);
    frame_tick = 1'b0;
    check_quiet("tick_after");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_x = 0; m_y = 0; m_pend = '0; m_armed = '0; m_level = '0; m_start = 0;
    check_quiet("reset");
    step(3);
    rst_n = 1'b1;
    step(12);
    settle();
    check_quiet("reset_release");
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    held = '0;
    drive('0);
    m_x = 0; m_y = 0; m_pend = '0; m_armed = '0; m_level = '0; m_start = 0;
    step(3);
    check_quiet("por");
    rst_n = 1'b1;
    step(1);

    // press up, one move up
    phase(4'b0000);
    phase(4'b0001);
    tick(0);
    phase(4'b0000);
    // short glitch is ignored
    glitch(0);
    tick(0);

    // right+up together from (0,0): up first, then right, then nothing
    do_reset();
    phase(4'b0101);
    phase(4'b0000);
    tick(0);
    tick(0);
    tick(0);

    // down at the bottom edge
    do_reset();
    phase(4'b0010);
    phase(4'b0000);
    tick(0);

    // held left across several ticks moves only once
    do_reset();
    phase(4'b0100);
    phase(4'b0000);
    tick(0);
    phase(4'b1000);
    tick(0);
    step(20);
    tick(1);
    step(20);
    tick(0);
    phase(4'b0000);

    // up pending when reset hits, still held through release
    do_reset();
    phase(4'b0001);
    do_reset();
    tick(0);
    phase(4'b0001);
    tick(0);
    phase(4'b0000);
    phase(4'b0001);
    tick(0);

    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 5))
        0, 1: phase(4'($urandom_range(0, 15)));
        2:    glitch($urandom_range(0, 3));
        3:    tick(0);
        4:    tick(1);
        default: if ($urandom_range(0, 3) == 0) do_reset(); else tick(0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, the number of cycles a synchronized button must be stable before acceptance (5 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have ports up, down, right, left, input, 1 each, raw asynchronous push-button levels, 1 = pressed.
REQ-005 SHALL have port frame_tick, input, 1, one-cycle pulse at vblank start from the VGA timing block.
REQ-006 SHALL have ports pos_x, pos_y, output, 1 each, player square on the 2x2 grid (x: 0 left/1 right; y: 0 lower/1 upper).
REQ-007 SHALL have port move_valid, output, 1, one-cycle pulse when the position changed.
REQ-008 SHALL have port move_blocked, output, 1, one-cycle pulse when a granted move hit the grid edge and position held.
REQ-009 SHALL have port busy, output, 1, high while any direction request is pending.

Function
REQ-010 Each button SHALL pass a 2-flop synchronizer, then a debouncer: the debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-011 A 0->1 edge of a debounced level SHALL set that direction's pending bit; holding a button SHALL NOT generate repeats.
REQ-012 A press on a direction already pending SHALL be dropped (single-entry per direction).
REQ-013 Pending requests SHALL be granted only in the cycle frame_tick=1, at most one grant per frame_tick.
REQ-014 Arbitration SHALL be round-robin in order UP, DOWN, RIGHT, LEFT, starting after the last granted direction; after reset the search starts at UP.
REQ-015 The granted pending bit SHALL clear in the grant cycle; a new edge of that same direction in the same cycle SHALL re-set it.
REQ-016 Move rules: UP sets y=1, DOWN y=0, RIGHT x=1, LEFT x=0; no-change move = blocked (default build).
REQ-017 Grant at cycle t SHALL update pos_x/pos_y at t+1 and pulse exactly one of move_valid/move_blocked at t+1 (latency 1).
REQ-018 FSM states: IDLE (no pending), PENDING (>=1 pending, awaiting frame_tick), COMMIT (one cycle, outputs pulse); COMMIT -> PENDING if pending remain else IDLE; frame_tick in COMMIT is ignored.
REQ-019 Opposite directions both pending SHALL both be served, one per frame_tick, in round-robin order.
REQ-020 frame_tick with no pending requests SHALL cause no output change.
REQ-021 busy SHALL equal OR of pending bits, registered.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear pos_x=0, pos_y=0, move_valid=0, move_blocked=0, busy=0, pending bits, synchronizers, debounce counters/levels, RR pointer to UP, FSM to IDLE.
REQ-023 Reset mid-debounce or mid-COMMIT SHALL discard all in-flight presses; a button held through reset release SHALL NOT produce a move until released and re-pressed.

Configuration
REQ-024 Macro PLAYER_MOVE_WRAP_EN: when defined, a move off the grid edge SHALL toggle the coordinate (e.g. UP at y=1 gives y=0) and pulse move_valid; move_blocked SHALL tie to 0.
REQ-025 Without PLAYER_MOVE_WRAP_EN, edge moves SHALL saturate per REQ-016.

Structure
REQ-026 Package game_pkg SHALL hold dir_t enum (DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT), grid_pos_t struct {x,y}, FSM state enum, and DIR_COUNT=4.
REQ-027 Sub-module button_debounce (synchronizer + counter + rising-edge pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated four times.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Reset, then press up for 10 cycles, frame_tick -> next cycle pos_y=1, move_valid=1 for 1 cycle, busy=0.
REQ-029 up glitch of 2 cycles, then frame_tick -> no pending, busy=0, pos unchanged (0,0).
REQ-030 At (0,0) press right and up together, three frame_ticks -> tick1 pos (0,1), tick2 pos (1,1), tick3 no change.
REQ-031 At (0,0) press down, frame_tick -> default: move_blocked=1, pos (0,0); with PLAYER_MOVE_WRAP_EN: move_valid=1, pos (0,1).
REQ-032 Hold left 100 cycles across 3 frame_ticks from (1,0) -> exactly one move to (0,0).
REQ-033 Press up, assert rst_n=0 before frame_tick, release with up still held, frame_tick -> pos (0,0), no pulses.
